// File: rtl/ff_bank_arbiter_if.sv
// Request/grant bundle between client FSMs and the shared flip-flop bank.
// master: clients drive req/lock/op/wdata; slave: the arbiter returns gnt/owner/busy/q/qbar.
interface ff_bank_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [2*NUM_REQ-1:0]          op;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [OW-1:0]                 owner;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         q;
    logic [DATA_WIDTH-1:0]         qbar;

    modport master (
        output req, lock, op, wdata,
        input  gnt, owner, busy, q, qbar
    );

    modport slave (
        input  req, lock, op, wdata,
        output gnt, owner, busy, q, qbar
    );
endinterface

// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter sharing one DATA_WIDTH-bit flip-flop bank among NUM_REQ clients.
// Ports: clk, rstn (sync, active-high), bus (slave: req/lock/op/wdata in; gnt/owner/busy/q/qbar out).
module ff_bank_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    ff_bank_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_TOGGLE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    state_t                state;
    logic [NUM_REQ-1:0]    gnt_r;
    logic [OW-1:0]         owner_r;
    logic [OW-1:0]         ptr_r;
    logic [CW-1:0]         cnt_r;
    logic [DATA_WIDTH-1:0] q_r;

    op_t                   cur_op;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  xfer;
    logic                  retain;
    logic                  found;
    logic [OW-1:0]         winner;
    logic [OW-1:0]         cand;
    logic [OW-1:0]         ptr_nxt;
    logic [DATA_WIDTH-1:0] q_nxt;

    // Select the owner's opcode and data slice.
    always_comb begin
        cur_op   = OP_NOP;
        cur_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_r == OW'(i)) begin
                cur_op   = op_t'(bus.op[2*i +: 2]);
                cur_data = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A granted owner that still requests performs its op this cycle.
    assign xfer   = (state == GRANT) && bus.req[owner_r];
    assign retain = xfer && bus.lock[owner_r]
                    && (cnt_r < CW'(MAX_BURST));

    // Round-robin scan starting at the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = OW'((int'(ptr_r) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign ptr_nxt = (winner == OW'(NUM_REQ - 1)) ? '0
                                                  : winner + 1'b1;

    always_comb begin
        q_nxt = q_r;
        if (xfer) begin
            unique case (cur_op)
                OP_LOAD:   q_nxt = cur_data;
                OP_TOGGLE: q_nxt = q_r ^ cur_data;
                OP_CLEAR:  q_nxt = '0;
                default:   q_nxt = q_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            gnt_r   <= '0;
            owner_r <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
            q_r     <= '0;
        end else begin
            q_r <= q_nxt;
            if (retain) begin
                cnt_r <= cnt_r + 1'b1;
            end else if (found) begin
                state   <= GRANT;
                gnt_r   <= NUM_REQ'(1) << winner;
                owner_r <= winner;
                ptr_r   <= ptr_nxt;
                cnt_r   <= CW'(1);
            end else begin
                state <= IDLE;
                gnt_r <= '0;
                cnt_r <= '0;
            end
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.owner = owner_r;
    assign bus.busy  = |gnt_r;
    assign bus.q     = q_r;
    assign bus.qbar  = ~q_r;

    a_gnt_onehot : assert property (
        @(posedge clk) $onehot0(gnt_r)
    );

    a_state_busy : assert property (
        @(posedge clk) (state == GRANT) == (|gnt_r)
    );
endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Scoreboard bench for ff_bank_arbiter: a cycle model predicts each edge,
// directed scenarios add fixed expectations, then a random phase runs.
module tb_ff_bank_arbiter;
    localparam int NR = 4;
    localparam int DW = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [1:0]    owner;
        logic          busy;
        logic [DW-1:0] q;
        logic [DW-1:0] qbar;
    } exp_t;

    logic clk;
    logic rstn;

    ff_bank_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    ff_bank_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    exp_t sb[$];

    logic [NR-1:0] m_gnt   = '0;
    int            m_owner = 0;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    logic [DW-1:0] m_q     = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t          e;
        bit            hold;
        bit            hit;
        int            c;
        logic [1:0]    opc;
        logic [DW-1:0] d;
        if (rstn) begin
            m_gnt = '0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = '0;
        end else begin
            hold = (m_gnt != 0) && bus.req[m_owner];
            opc  = bus.op[2*m_owner +: 2];
            d    = bus.wdata[DW*m_owner +: DW];
            if (hold) begin
                if (opc == 2'b01) m_q = d;
                else if (opc == 2'b10) m_q = m_q ^ d;
                else if (opc == 2'b11) m_q = '0;
            end
            if (hold && bus.lock[m_owner] && m_cnt < MB) begin
                m_cnt++;
            end else begin
                hit = 0;
                for (int k = 0; k < NR; k++) begin
                    c = (m_ptr + k) % NR;
                    if (!hit && bus.req[c]) begin
                        hit = 1;
                        m_owner = c;
                        m_gnt = '0;
                        m_gnt[c] = 1'b1;
                        m_ptr = (c + 1) % NR;
                        m_cnt = 1;
                    end
                end
                if (!hit) m_gnt = '0;
            end
        end
        e.gnt   = m_gnt;
        e.owner = 2'(m_owner);
        e.busy  = (m_gnt != 0);
        e.q     = m_q;
        e.qbar  = ~m_q;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_gnt",  32'(bus.gnt),  32'(e.gnt));
            chk("sb_busy", 32'(bus.busy), 32'(e.busy));
            chk("sb_q",    32'(bus.q),    32'(e.q));
            chk("sb_qbar", 32'(bus.qbar), 32'(e.qbar));
            if (e.busy) chk("sb_owner", 32'(bus.owner), 32'(e.owner));
        end
    endtask

    task automatic set_op(input int i, input logic [1:0] o,
                          input logic [DW-1:0] d);
        bus.op[2*i +: 2]     = o;
        bus.wdata[DW*i +: DW] = d;
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b1;
        repeat (n) tick();
        rstn = 1'b0;
    endtask

    logic [NR-1:0] t3_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [DW-1:0] t3_q [5] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3};
    logic [NR-1:0] t4_g [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    initial begin
        rstn      = 1'b1;
        bus.req   = '1;
        bus.lock  = '0;
        bus.op    = '0;
        bus.wdata = '0;

        // 1: reset with all requests pending
        do_reset(2);
        rstn = 1'b1;
        chk("t1_gnt",   32'(bus.gnt),   32'h0);
        chk("t1_busy",  32'(bus.busy),  32'h0);
        chk("t1_q",     32'(bus.q),     32'h0);
        chk("t1_qbar",  32'(bus.qbar),  32'hF);
        chk("t1_owner", 32'(bus.owner), 32'h0);
        rstn = 1'b0;
        tick();
        chk("t1_first", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        tick();
        chk("t1_idle", 32'(bus.busy), 32'h0);

        // 2: single requester LOAD / TOGGLE / CLEAR
        bus.req = 4'b0001;
        set_op(0, 2'b01, 4'hA);
        tick();
        chk("t2_gnt", 32'(bus.gnt), 32'h1);
        tick();
        chk("t2_load", 32'(bus.q), 32'hA);
        set_op(0, 2'b10, 4'hF);
        tick();
        chk("t2_tog", 32'(bus.q), 32'h5);
        set_op(0, 2'b11, 4'h9);
        tick();
        chk("t2_clr", 32'(bus.q), 32'h0);
        bus.req = '0;
        tick();

        // 3: all request, no lock, each loads its index
        for (int i = 0; i < NR; i++) set_op(i, 2'b01, DW'(i));
        bus.req = '1;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_gnt", 32'(bus.gnt), 32'(t3_g[i]));
            chk("t3_q",   32'(bus.q),   32'(t3_q[i]));
        end
        tick();
        chk("t3_wrap_q", 32'(bus.q), 32'h0);

        // 4: locked bursts, bounded by MAX_BURST
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        bus.op   = '0;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_gnt", 32'(bus.gnt), 32'(t4_g[i]));
        end
        bus.req = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t4_sole", 32'(bus.gnt), 32'h1);
        end

        // 5: owner drops req during its grant
        bus.lock = '0;
        bus.req  = 4'b0100;
        set_op(2, 2'b01, 4'h9);
        do_reset(1);
        tick();
        tick();
        chk("t5_pre_q", 32'(bus.q), 32'h9);
        bus.req = 4'b1001;
        set_op(2, 2'b01, 4'h7);
        tick();
        chk("t5_hold_q", 32'(bus.q),   32'h9);
        chk("t5_ptr3",   32'(bus.gnt), 32'h8);

        // 6: reset mid-burst discards pending TOGGLE
        bus.req  = 4'b0010;
        bus.lock = 4'b0010;
        bus.op   = '0;
        set_op(1, 2'b01, 4'h6);
        do_reset(1);
        tick();
        tick();
        chk("t6_load", 32'(bus.q), 32'h6);
        set_op(1, 2'b10, 4'h3);
        tick();
        chk("t6_tog", 32'(bus.q), 32'h5);
        rstn = 1'b1;
        tick();
        chk("t6_rst_q",    32'(bus.q),    32'h0);
        chk("t6_rst_gnt",  32'(bus.gnt),  32'h0);
        chk("t6_rst_qbar", 32'(bus.qbar), 32'hF);
        rstn     = 1'b0;
        bus.req  = '1;
        bus.lock = '0;
        tick();
        chk("t6_ptr0", 32'(bus.gnt), 32'h1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rstn      = ($urandom_range(0, 59) == 0);
            bus.req   = NR'($urandom);
            bus.lock  = NR'($urandom);
            bus.op    = (2*NR)'($urandom);
            bus.wdata = (NR*DW)'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ff_bank_arbiter.md
Name: ff_bank_arbiter

Overview:
- Shares a single DATA_WIDTH-bit flip-flop bank between NUM_REQ requesters.
- Each requester issues LOAD (D-style), TOGGLE (T-style: q ^= data) or CLEAR operations through a registered req/gnt handshake.
- Round-robin arbitration, with an optional lock for bounded back-to-back bursts.
- Sits between client FSMs and the shared q/qbar state.

Parameters:
- NUM_REQ, 4, number of requesters (>= 2)
- DATA_WIDTH, 4, width of the flip-flop bank
- MAX_BURST, 4, max consecutive grant cycles to one requester under lock (>= 1)

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous reset, active-high (1 = reset)
- req  input  NUM_REQ  request per requester
- lock  input  NUM_REQ  request to retain grant after current cycle
- op  input  2*NUM_REQ  per-requester opcode, slice [2i+1:2i]: 00 NOP, 01 LOAD, 10 TOGGLE, 11 CLEAR
- wdata  input  NUM_REQ*DATA_WIDTH  per-requester data, slice [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  output  NUM_REQ  registered one-hot grant
- owner  output  $clog2(NUM_REQ)  index of the granted requester; valid when busy=1
- busy  output  1  = |gnt
- q  output  DATA_WIDTH  bank state
- qbar  output  DATA_WIDTH  always ~q

Behaviour:
- Reset (rstn=1 at edge): q=0, qbar=all 1s, gnt=0, busy=0, owner=0, rr pointer=0, burst count=0. Any in-flight op is discarded. Reset overrides all other activity.
- States: IDLE (gnt=0) and GRANT (exactly one gnt bit set). busy=1 iff GRANT.
- Arbitration happens at each edge when not retaining:
  - Scan req starting at the rr pointer, wrapping modulo NUM_REQ.
  - First set bit wins: gnt<=onehot(winner), owner<=winner, pointer<=(winner+1) mod NUM_REQ, burst count<=1.
  - No req set: go to IDLE, gnt<=0.
- Retain: the current owner i keeps the grant at the edge when all of these hold: in GRANT, req[i]=1, lock[i]=1, burst count<MAX_BURST. Burst count increments; pointer unchanged.
- Forced release: at burst count==MAX_BURST the grant is re-arbitrated. Because the pointer is already past i, other requesters win. i regains only if it is the sole requester, which starts a new burst with count 1.
- Transfer: occurs in a cycle where gnt[i]=1 and req[i]=1. At the ending edge, q updates per op[i]:
  - LOAD: q<=wdata[i]
  - TOGGLE: q<=q^wdata[i]
  - CLEAR: q<=0
  - NOP: q unchanged
- If req[i]=0 during its grant cycle, there is no transfer and q is held.
- Latency: req sampled at edge N, gnt high during cycle N..N+1, q updated at edge N+1. A lone requester holding req gets one transfer per cycle from edge N+1 onward.
- A non-granted requester's op/wdata never affects q. At most one op per cycle.
- Back-to-back grants to different requesters carry no idle bubble.
- lock from a non-owner is ignored. lock with req=0 does not retain.
- TOGGLE with wdata=0 leaves q unchanged. CLEAR ignores wdata.
- qbar is combinational from q and never diverges from ~q, including during reset.

Test Plan:
1. Reset with rstn=1 for 2 cycles, all req=1 -> gnt=0, busy=0, q=4'h0, qbar=4'hF. First grant goes to req0 one edge after rstn falls.
2. req0 only, op=LOAD, wdata=4'hA -> gnt=4'b0001 next cycle. q=4'hA one edge later. Then op=TOGGLE, wdata=4'hF gives q=4'h5. Then CLEAR gives q=4'h0.
3. req=4'b1111 held, lock=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, no idle cycles. Each requester performs LOAD of its index, so q sequence is 0, 1, 2, 3, 0.
4. req=4'b0011, lock[0]=1, MAX_BURST=4 -> gnt=0001 for exactly 4 cycles, then 0010. With lock[0] still 1, grant returns to req0 after req1.
5. gnt[2]=1 while req[2] drops to 0, op=LOAD, wdata=4'h7 -> q unchanged. Next arbitration proceeds from pointer=3.
6. rstn asserted during a req1 lock burst with pending TOGGLE -> q=0, gnt=0, pointer=0 after the edge. The TOGGLE is not applied.
